piso_tx: RTL
============

Name: piso_tx

Overview:
Parallel-in/serial-out transmitter that accepts a WIDTH-bit word over a valid/ready handshake and shifts it out one bit per enabled clock. It is the sending end of the team's serial datapath, built from clocked storage like the master-slave DFF chain. It drives framing and completion strobes so a downstream serial receiver can capture the word.

Parameters:
WIDTH, 8, word length in bits (must be at least 2)
MSB_FIRST, 1, 1 = transmit din[WIDTH-1] first; 0 = transmit din[0] first
IDLE_LEVEL, 0, level driven on sout when no word is in flight

Ports:
clk  input  1  single clock, rising edge
rst  input  1  reset, synchronous, active-high
din  input  WIDTH  parallel word to send
din_valid  input  1  din is valid this cycle
din_ready  output  1  transmitter can accept a word this cycle
en  input  1  bit-advance enable (baud tick), sampled at the rising edge
sout  output  1  serial data, registered
sframe  output  1  high while a data bit is on sout, registered
busy  output  1  high in SHIFT or DONE
done  output  1  one-cycle pulse after the last bit finishes, registered

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- Reset: rst=1 at an edge puts the block in IDLE and sets shreg=0, cnt=0, sout=IDLE_LEVEL, sframe=0, done=0. din_ready is 1 from the cycle after reset. Reset mid-word aborts the word with no done pulse, and the partial word is discarded.
- States: IDLE, SHIFT, DONE.
- IDLE: din_ready=1 and busy=0. At an edge with din_valid=1, the block performs all of the following and goes to SHIFT:
  - shreg<=din
  - sout<=first bit
  - sframe<=1
  - cnt<=0
- IDLE with din_valid=0: outputs hold; sout stays IDLE_LEVEL.
- SHIFT: din_ready=0; din and din_valid are ignored.
  - en=0: everything holds, so a bit may be stretched for any number of cycles.
  - en=1 and cnt<WIDTH-1: shreg shifts toward the transmit end, sout<=next bit, cnt<=cnt+1.
  - en=1 and cnt==WIDTH-1: sout<=IDLE_LEVEL, sframe<=0, done<=1, go to DONE.
- DONE: lasts exactly one cycle with done=1 and din_ready=0, then done<=0 and the block returns to IDLE.
- Bit hold: each bit is on sout from the cycle after it is loaded or shifted until the edge where en=1 advances it.
- Timing with en tied high, where cycle 0 is the accept edge:
  - bit k on sout during cycle k+1, for k=0..WIDTH-1
  - done high during cycle WIDTH+1
  - din_ready high again in cycle WIDTH+2
  - minimum word period is WIDTH+2 cycles
- en asserted in IDLE or DONE: no effect.
- cnt width: clog2(WIDTH). cnt never exceeds WIDTH-1 and does not wrap.
- Simultaneous events: rst has priority over the handshake and over en. din_valid held high continuously gets a new word accepted in every IDLE cycle.

Decomposition:
- Package piso_pkg holds:
  - state encoding (IDLE=2'd0, SHIFT=2'd1, DONE=2'd2)
  - the clog2-based counter-width helper
  - the default WIDTH constant
- One sub-module, tx_bit_counter: a synchronous-reset counter with clear, enable and a last flag (cnt==WIDTH-1), used by the FSM.
- Shift register, FSM and output registers stay in piso_tx.

Test Plan:
1. Reset: assert rst for 2 cycles, with din_valid=1 held during reset -> sout=0, sframe=0, done=0, busy=0; din_ready=1 in the first cycle after rst falls.
2. WIDTH=8, MSB_FIRST=1, en=1, send 8'hA5 -> sout=1,0,1,0,0,1,0,1 in cycles 1..8; sframe=1 in cycles 1..8; done=1 only in cycle 9; din_ready=1 in cycle 10.
3. MSB_FIRST=0, send 8'h01 with en pulsed every 3rd cycle -> first bit 1 then seven 0s, each held 3 cycles; done exactly once.
4. Back-to-back: din_valid held high with 8'hFF then 8'h00 -> the second word is accepted in cycle 10, and the 8'hFF bits are never corrupted by the second word.
5. Reset mid-word: assert rst after 3 bits of 8'hC3 -> next cycle sout=IDLE_LEVEL, sframe=0, no done pulse, din_ready=1.
6. Stall: en=0 for 20 cycles during bit 4 -> sout, sframe and cnt are stable; transmission resumes on the next en with correct remaining bits.

Source files
------------

// File: rtl/piso_pkg.sv
// Shared definitions for the piso_tx serial transmitter.
//   state_t       : FSM state encoding
//   cnt_width()   : bit-counter width for a given word length
//   DEFAULT_WIDTH : default word length in bits
package piso_pkg;

    localparam int unsigned DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    // Width needed to count bit positions 0..w-1 (at least one bit).
    function automatic int unsigned cnt_width(input int unsigned w);
        return (w < 2) ? 1 : $clog2(w);
    endfunction

endpackage : piso_pkg

// File: rtl/tx_bit_counter.sv
// Bit-position counter for the serial transmitter.
//   clk    : clock, rising edge
//   rst    : synchronous active-high reset (count -> 0)
//   clr    : synchronous clear (count -> 0)
//   inc    : advance the count; saturates at WIDTH-1
//   last_c : count is at WIDTH-1 (combinational decode of the count)
module tx_bit_counter
    import piso_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic inc,
    output logic last_c
);

    localparam int unsigned   CW       = cnt_width(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    logic [CW-1:0] cnt;

    // Count register; holding at the last position keeps it from wrapping.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt <= '0;
        end else if (inc && !last_c) begin
            cnt <= cnt + CW'(1);
        end
    end

    assign last_c = (cnt == CNT_LAST);

endmodule : tx_bit_counter

// File: rtl/piso_tx.sv
// Parallel-in/serial-out transmitter with valid/ready word intake.
//   clk       : clock, rising edge
//   rst       : synchronous active-high reset
//   din       : parallel word to send
//   din_valid : din is valid this cycle
//   din_ready : transmitter can accept a word this cycle (registered)
//   en        : bit-advance enable (baud tick)
//   sout      : serial data (registered)
//   sframe    : a data bit is on sout (registered)
//   busy      : word in flight, SHIFT or DONE (registered)
//   done      : one-cycle pulse after the last bit (registered)
module piso_tx
    import piso_pkg::*;
#(
    parameter int unsigned WIDTH      = DEFAULT_WIDTH,
    parameter bit          MSB_FIRST  = 1'b1,
    parameter bit          IDLE_LEVEL = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    input  logic             en,
    output logic             sout,
    output logic             sframe,
    output logic             busy,
    output logic             done
);

    state_t           state;
    logic [WIDTH-1:0] shreg;
    logic [WIDTH-1:0] shift_c;
    logic             first_bit_c;
    logic             next_bit_c;
    logic             load_c;
    logic             adv_c;
    logic             last_c;

    // Transmit-end selection: the bit already on sout sits at the transmit
    // end of shreg, so the next bit is its neighbour.
    always_comb begin
        first_bit_c = MSB_FIRST ? din[WIDTH-1] : din[0];
        next_bit_c  = MSB_FIRST ? shreg[WIDTH-2] : shreg[1];
        if (MSB_FIRST) begin
            shift_c = {shreg[WIDTH-2:0], 1'b0};
        end else begin
            shift_c = {1'b0, shreg[WIDTH-1:1]};
        end
    end

    assign load_c = (state == ST_IDLE) && din_valid;
    assign adv_c  = (state == ST_SHIFT) && en;

    tx_bit_counter #(
        .WIDTH (WIDTH)
    ) u_cnt (
        .clk    (clk),
        .rst    (rst),
        .clr    (load_c),
        .inc    (adv_c),
        .last_c (last_c)
    );

    // Control FSM with shift register and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            shreg     <= '0;
            sout      <= IDLE_LEVEL;
            sframe    <= 1'b0;
            done      <= 1'b0;
            busy      <= 1'b0;
            din_ready <= 1'b1;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (din_valid) begin
                        shreg     <= din;
                        sout      <= first_bit_c;
                        sframe    <= 1'b1;
                        busy      <= 1'b1;
                        din_ready <= 1'b0;
                        state     <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    if (en) begin
                        if (last_c) begin
                            sout   <= IDLE_LEVEL;
                            sframe <= 1'b0;
                            done   <= 1'b1;
                            state  <= ST_DONE;
                        end else begin
                            shreg <= shift_c;
                            sout  <= next_bit_c;
                        end
                    end
                end
                ST_DONE: begin
                    done      <= 1'b0;
                    busy      <= 1'b0;
                    din_ready <= 1'b1;
                    state     <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule : piso_tx
